// File: rtl/wbsel_pkg.sv
// Shared result/redirect bundle types and the modular op-order test used by every
// execution unit and by the writeback selector.
package wbsel_pkg;

  typedef struct packed {
    logic [15:0] opid;   // bit 15 = valid
    logic [63:0] data;
    logic        exc;
  } exe_bundle_t;

  typedef struct packed {
    logic [15:0] opid;   // bit 15 = redirect active
    logic [15:0] topid;  // oldest in-flight op
  } red_bundle_t;

  // Order is purely relative to topid in $clog2(opsz)-bit arithmetic, so opid wrap is harmless.
  function automatic logic younger(input logic [15:0] x, input red_bundle_t redir,
                                   input int opsz);
    logic [15:0] mask;
    logic [15:0] dx;
    logic [15:0] dr;
    mask = 16'((1 << $clog2(opsz)) - 1);
    dx   = (x - redir.topid) & mask;
    dr   = (redir.opid - redir.topid + 16'd1) & mask;
    return redir.opid[15] && x[15] && (dx >= dr);
  endfunction

endpackage

// File: rtl/wbsel_if.sv
// Result-offer / claim / writeback bundle between the execution units and wbsel.
interface wbsel_if #(
  parameter int nfu = 4,
  parameter int ewd = 4,
  parameter int wwd = 4
);
  import wbsel_pkg::*;

  localparam int nw = $clog2(wwd) + 1;

  red_bundle_t                      redir;
  exe_bundle_t [nfu-1:0][ewd-1:0]   resp;
  logic        [nfu-1:0][ewd-1:0]   claim;
  logic                             wb_ready;
  exe_bundle_t [wwd-1:0]            wb;
  logic        [nw-1:0]             wb_num;

  modport slave  (input  redir, resp, wb_ready, output claim, wb, wb_num);
  modport master (output redir, resp, wb_ready, input  claim, wb, wb_num);

endinterface

// File: rtl/wbsel_wbpack.sv
// Rotating first-N picker: from a flattened candidate mask, starting at FU `start`,
// returns up to wwd slot indices in pick order plus the matching grant mask.
module wbpack #(
  parameter int nslot  = 16,
  parameter int stride = 4,
  parameter int wwd    = 4,
  parameter int sw     = 2,
  parameter int iw     = (nslot > 1) ? $clog2(nslot) : 1
) (
  input  logic [nslot-1:0]          cand,
  input  logic [sw-1:0]             start,
  output logic [wwd-1:0][iw-1:0]    idx,
  output logic [wwd-1:0]            vld,
  output logic [nslot-1:0]          grant
);

  always_comb begin
    int          cnt;
    int          pi;
    logic [iw-1:0] pos;
    // NOTE: every output gets a default before the loop so no path infers a latch.
    idx   = '0;
    vld   = '0;
    grant = '0;
    cnt   = 0;
    for (int k = 0; k < nslot; k++) begin
      pi = k + int'(start) * stride;
      if (pi >= nslot) pi = pi - nslot;
      pos = iw'(pi);
      if (cand[pos] && cnt < wwd) begin
        for (int p = 0; p < wwd; p++) begin
          if (p == cnt) begin
            idx[p] = pos;
            vld[p] = 1'b1;
          end
        end
        grant[pos] = 1'b1;
        cnt        = cnt + 1;
      end
    end
  end

endmodule

// File: rtl/wbsel.sv
// Writeback selector: claims up to wwd finished results per cycle in rotating FU order,
// registers them onto the writeback ports, and squashes anything younger than a redirect.
module wbsel
  import wbsel_pkg::*;
#(
  parameter int nfu  = 4,
  parameter int ewd  = 4,
  parameter int wwd  = 4,
  parameter int opsz = 64
) (
  input  logic    clk,
  input  logic    rst,
  wbsel_if.slave  bus
);

  localparam int nslot = nfu * ewd;
  localparam int iw    = (nslot > 1) ? $clog2(nslot) : 1;
  localparam int pw    = (nfu > 1) ? $clog2(nfu) : 1;
  localparam int nw    = $clog2(wwd) + 1;

  exe_bundle_t              flat [nslot];
  logic [nslot-1:0]         cand;
  logic [nslot-1:0]         req;
  logic [nslot-1:0]         grant;
  logic [wwd-1:0][iw-1:0]   idx;
  logic [wwd-1:0]           vld;
  logic [pw-1:0]            rr_ptr;

  exe_bundle_t [wwd-1:0]    wb_q;
  exe_bundle_t [wwd-1:0]    wb_d;
  exe_bundle_t              base [wwd];
  logic [wwd-1:0]           keep;
  logic [nw-1:0]            num_q;
  logic [nw-1:0]            num_d;

  always_comb begin
    for (int f = 0; f < nfu; f++) begin
      for (int s = 0; s < ewd; s++) begin
        flat[f*ewd+s] = bus.resp[f][s];
        cand[f*ewd+s] = bus.resp[f][s].opid[15] &&
                        !younger(bus.resp[f][s].opid, bus.redir, opsz);
      end
    end
    // No grants while stalled or in reset, whatever the FUs offer.
    req = (bus.wb_ready && !rst) ? cand : '0;
  end

  wbpack #(
    .nslot (nslot),
    .stride(ewd),
    .wwd   (wwd),
    .sw    (pw),
    .iw    (iw)
  ) u_pack (
    .cand (req),
    .start(rr_ptr),
    .idx  (idx),
    .vld  (vld),
    .grant(grant)
  );

  always_comb begin
    for (int f = 0; f < nfu; f++) begin
      for (int s = 0; s < ewd; s++) begin
        bus.claim[f][s] = grant[f*ewd+s];
      end
    end
  end

  // Load or hold, squash young entries with the current redirect, then repack from port 0.
  always_comb begin
    int n;
    for (int p = 0; p < wwd; p++) begin
      if (bus.wb_ready) base[p] = vld[p] ? flat[idx[p]] : '0;
      else              base[p] = wb_q[p];
      keep[p] = base[p].opid[15] && !younger(base[p].opid, bus.redir, opsz);
    end
    wb_d = '0;
    n    = 0;
    for (int q = 0; q < wwd; q++) begin
      if (keep[q]) begin
        for (int p = 0; p < wwd; p++) begin
          if (p == n) wb_d[p] = base[q];
        end
        n = n + 1;
      end
    end
    num_d = nw'(n);
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use <= so each one samples the pre-edge values of the others.
    if (rst) begin
      wb_q   <= '0;
      num_q  <= '0;
      rr_ptr <= '0;
    end else begin
      wb_q  <= wb_d;
      num_q <= num_d;
      if (|grant) rr_ptr <= (rr_ptr == pw'(nfu - 1)) ? '0 : rr_ptr + 1'b1;
    end
  end

  assign bus.wb     = wb_q;
  assign bus.wb_num = num_q;

endmodule

// File: tb/tb_wbsel.sv
// Scenario bench for wbsel: expected writeback contents are queued when stimulus is
// driven and popped when the registered output is sampled one cycle later.
module tb_wbsel;
  import wbsel_pkg::*;

  localparam int nfu = 4, ewd = 4, wwd = 4, opsz = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wbsel_if #(.nfu(nfu), .ewd(ewd), .wwd(wwd)) bus();

  wbsel #(.nfu(nfu), .ewd(ewd), .wwd(wwd), .opsz(opsz)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    logic [2:0]       num;
    logic [3:0][15:0] op;
  } exp_t;

  exp_t exp_q[$];

  function automatic exe_bundle_t mk(input logic [15:0] op);
    exe_bundle_t b;
    b.opid = op;
    b.data = {op, ~op, op ^ 16'h5a5a, 16'h1234};
    b.exc  = op[0];
    return b;
  endfunction

  task automatic clear_inputs();
    bus.resp     = '0;
    bus.redir    = '0;
    bus.wb_ready = 1'b1;
  endtask

  task automatic offer(input int f, input int s, input logic [15:0] op);
    bus.resp[f][s] = mk(op);
  endtask

  task automatic offer_all(input logic [15:0] base_op);
    for (int f = 0; f < nfu; f++)
      for (int s = 0; s < ewd; s++)
        offer(f, s, base_op + 16'(f*16 + s));
  endtask

  task automatic push_exp(input int num, input logic [15:0] o0, input logic [15:0] o1,
                          input logic [15:0] o2, input logic [15:0] o3);
    exp_t e;
    e.num = 3'(num);
    e.op  = {o3, o2, o1, o0};
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_claim(input string name, input logic [15:0] expm);
    #1;
    n_tests++;
    if (bus.claim !== expm) begin
      n_fail++;
      $display("FAIL %s claim: got %h want %h", name, bus.claim, expm);
    end
  endtask

  task automatic check_wb(input string name);
    exp_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: scoreboard empty, got wb_num %0d want an entry", name, bus.wb_num);
      return;
    end
    e = exp_q.pop_front();
    if (bus.wb_num !== e.num) begin
      n_fail++;
      $display("FAIL %s wb_num: got %0d want %0d", name, bus.wb_num, e.num);
    end
    for (int p = 0; p < wwd; p++) begin
      n_tests++;
      if (p < int'(e.num)) begin
        if (bus.wb[p] !== mk(e.op[p])) begin
          n_fail++;
          $display("FAIL %s wb[%0d]: got opid %h want %h", name, p, bus.wb[p].opid, e.op[p]);
        end
      end else if (bus.wb[p] !== '0) begin
        n_fail++;
        $display("FAIL %s wb[%0d]: got opid %h want all-zero", name, p, bus.wb[p].opid);
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    offer_all(16'h8300);
    check_claim("reset", 16'h0000);
    push_exp(0, 0, 0, 0, 0);
    tick();
    check_wb("reset");
    rst = 1'b0;
    clear_inputs();
  endtask

  // rr_ptr=0: five candidates, four ports; the fifth is taken next cycle.
  task automatic test_overflow();
    clear_inputs();
    offer(0, 0, 16'h8010); offer(1, 0, 16'h8020); offer(2, 0, 16'h8030);
    offer(3, 0, 16'h8040); offer(3, 1, 16'h8041);
    check_claim("overflow_a", 16'h1111);
    push_exp(4, 16'h8010, 16'h8020, 16'h8030, 16'h8040);
    tick();
    check_wb("overflow_a");
    bus.resp[0][0] = '0; bus.resp[1][0] = '0; bus.resp[2][0] = '0; bus.resp[3][0] = '0;
    check_claim("overflow_b", 16'h2000);
    push_exp(1, 16'h8041, 0, 0, 0);
    tick();
    check_wb("overflow_b");
    clear_inputs();
  endtask

  task automatic test_single();
    clear_inputs();
    offer(2, 0, 16'h8005);
    check_claim("single", 16'h0100);
    push_exp(1, 16'h8005, 0, 0, 0);
    tick();
    check_wb("single");
    clear_inputs();
  endtask

  // rr_ptr=3 here: FU3 wins first, then rotation wraps to FU0 at full rate.
  task automatic test_back_to_back();
    clear_inputs();
    offer_all(16'h8100);
    check_claim("b2b_a", 16'hF000);
    push_exp(4, 16'h8130, 16'h8131, 16'h8132, 16'h8133);
    tick();
    check_wb("b2b_a");
    for (int s = 0; s < ewd; s++) bus.resp[3][s] = '0;
    check_claim("b2b_b", 16'h000F);
    push_exp(4, 16'h8100, 16'h8101, 16'h8102, 16'h8103);
    tick();
    check_wb("b2b_b");
    clear_inputs();
  endtask

  task automatic test_redirect();
    clear_inputs();
    bus.redir.opid  = 16'h8014;
    bus.redir.topid = 16'd10;
    offer(0, 0, 16'h800F);
    offer(1, 0, 16'h8019);
    check_claim("redirect", 16'h0001);
    push_exp(1, 16'h800F, 0, 0, 0);
    tick();
    check_wb("redirect");
    clear_inputs();
  endtask

  task automatic test_stall_redirect();
    clear_inputs();
    offer(0, 0, 16'h801E);
    offer(0, 1, 16'h801F);
    check_claim("stall_load", 16'h0003);
    push_exp(2, 16'h801E, 16'h801F, 0, 0);
    tick();
    check_wb("stall_load");
    bus.resp[0][0] = '0;
    bus.resp[0][1] = '0;
    offer(1, 0, 16'h8014);
    bus.wb_ready    = 1'b0;
    bus.redir.opid  = 16'h801E;
    bus.redir.topid = 16'd0;
    check_claim("stall_squash", 16'h0000);
    push_exp(1, 16'h801E, 0, 0, 0);
    tick();
    check_wb("stall_squash");
    bus.redir = '0;
    check_claim("stall_hold", 16'h0000);
    push_exp(1, 16'h801E, 0, 0, 0);
    tick();
    check_wb("stall_hold");
    clear_inputs();
  endtask

  task automatic test_wrap();
    clear_inputs();
    bus.redir.opid  = 16'h803F;
    bus.redir.topid = 16'd62;
    offer(1, 2, 16'h8001);
    offer(2, 1, 16'h803F);
    check_claim("wrap", 16'h0200);
    push_exp(1, 16'h803F, 0, 0, 0);
    tick();
    check_wb("wrap");
    clear_inputs();
  endtask

  task automatic test_reset_mid();
    clear_inputs();
    offer(0, 0, 16'h8021); offer(0, 1, 16'h8022); offer(0, 2, 16'h8023);
    check_claim("rstmid_load", 16'h0007);
    push_exp(3, 16'h8021, 16'h8022, 16'h8023, 0);
    tick();
    check_wb("rstmid_load");
    rst             = 1'b1;
    bus.wb_ready    = 1'b0;
    bus.redir.opid  = 16'h8021;
    bus.redir.topid = 16'd0;
    offer_all(16'h8300);
    check_claim("rstmid_rst", 16'h0000);
    push_exp(0, 0, 0, 0, 0);
    tick();
    check_wb("rstmid_rst");
    rst = 1'b0;
    clear_inputs();
    offer_all(16'h8200);
    check_claim("rstmid_rr0", 16'h000F);
    push_exp(4, 16'h8200, 16'h8201, 16'h8202, 16'h8203);
    tick();
    check_wb("rstmid_rr0");
    clear_inputs();
    check_claim("empty", 16'h0000);
    push_exp(0, 0, 0, 0, 0);
    tick();
    check_wb("empty");
    offer_all(16'h8200);
    check_claim("empty_rr_hold", 16'h00F0);
    push_exp(4, 16'h8210, 16'h8211, 16'h8212, 16'h8213);
    tick();
    check_wb("empty_rr_hold");
    clear_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_overflow();
    test_single();
    test_back_to_back();
    test_redirect();
    test_stall_redirect();
    test_wrap();
    test_reset_mid();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d leftover entries want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wbsel.md
# wbsel

Writeback selector on the consumer side of the execution-unit result interface. Watches the `resp` slots of every functional unit, decides which finished results to take each cycle, asserts the matching `claim` lines, and registers the taken bundles onto `wwd` writeback ports for the physical register file and reorder buffer. Results younger than an active redirect are never claimed and are dropped from the output register.

## Interface
- `nfu`, default 4: number of functional units feeding the selector.
- `ewd`, default 4: result slots per functional unit.
- `wwd`, default 4: writeback ports.
- `opsz`, default 64: operation ID space; the order arithmetic uses $clog2(opsz) bits.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `redir`  in  red_bundle_t  redirect bundle; `opid[15]` is valid, `opid` is the redirecting op, `topid` is the oldest in-flight op.
- `resp`  in  exe_bundle_t [nfu-1:0][ewd-1:0]  offered results; a slot is valid when `opid[15]` is 1.
- `claim`  out  logic [nfu-1:0][ewd-1:0]  take strobe, combinational, same cycle as `resp`.
- `wb_ready`  in  1  downstream accepts the writeback register this cycle.
- `wb`  out  exe_bundle_t [wwd-1:0]  registered writeback bundles, packed from port 0 upward.
- `wb_num`  out  $clog2(wwd)+1  count of valid `wb` ports, registered.

## Operation
- Order test `younger(x)`:
  - true iff `redir.opid[15]` and `x[15]`;
  - and, in $clog2(opsz)-bit modular arithmetic, `x − topid ≥ redir.opid − topid + 1`.
- Candidate: a slot with `opid[15]=1` and `younger(opid)=0`.
- Selection order:
  - flatten the slots as FU-major, slot-minor;
  - start at FU `rr_ptr` and wrap modulo `nfu`.
  - take the first `min(wwd, #candidates)` in that order.
- Grants are allowed only when `wb_ready=1`. When `wb_ready=0`, every `claim` is 0.
- `claim[f][s]=1` exactly for granted slots. A slot is claimed at most once; after the edge the FU must withdraw or replace it.
- Register update at the edge:
  - if `wb_ready=1`: `wb` is loaded with the granted bundles, in grant order, starting at port 0. Unused ports are all-zero. `wb_num` is set to the grant count.
  - if `wb_ready=0`: `wb` holds.
  - in both cases, any held or loaded port with `younger(opid)=1` is zeroed and `wb_num` is decremented. Ports are then repacked so valid entries stay contiguous from port 0.
- `rr_ptr` advances by 1 modulo `nfu` on every edge where at least one grant occurred. Otherwise it holds.
- Slots with `younger=1` are left unclaimed. The owning FU flushes them on the same redirect.

## Timing
- Reset: `wb`=0, `wb_num`=0, `rr_ptr`=0. `claim` is 0 during reset regardless of `resp`.
- Latency: a bundle claimed in cycle t appears on `wb` in cycle t+1.
- Throughput: `wwd` results per cycle sustained.
- Redirect and grant in the same cycle: the squash test uses the current `redir` on both the candidate mask and the register update. A young result can never reach `wb`.
- All slots empty: `claim`=0, `wb` is loaded with zeros, `wb_num`=0, `rr_ptr` holds.
- More than `wwd` candidates: the excess stays unclaimed and is re-offered next cycle. Rotation bounds starvation to `nfu` cycles per FU.
- `opid` wrap-around: order is purely modular relative to `topid`. No absolute comparison is used.
- `rst` during a stall or redirect: reset wins and all state clears at that edge.

## Structure
- `types` package:
  - `exe_bundle_t` and `red_bundle_t` (existing);
  - the shared order function `younger(opid, redir, opsz)`, so every execution unit and this block use identical arithmetic.
- Sub-module `wbpack`, combinational:
  - input: the flattened candidate mask and rotation start;
  - output: up to `wwd` slot indices plus the grant mask.
- The top level holds `rr_ptr`, the `wb` register, squash and repacking.

## Test plan
- Single FU 2, slot 0, `opid=16'h8005`, `wb_ready=1`, no redirect → `claim[2][0]=1` that cycle; next cycle `wb[0].opid=16'h8005`, `wb_num=1`.
- Five candidates, `wwd=4`, `rr_ptr=0` → FUs 0..3 slot 0 are claimed; FU 3 slot 1 is claimed in the following cycle; `rr_ptr`=1.
- Redirect with `topid=10`, `redir.opid=20`; `resp` opids 15 and 25 (bit 15 set) → only 15 is claimed; `wb_num=1`.
- `wb_ready=0` with `wb_num=2` held (opids 30 and 31), then redirect with `redir.opid=30` → `claim`=0; next cycle `wb[0].opid=30`, `wb[1]`=0, `wb_num=1`.
- Wrap case, `topid=62`, `redir.opid=63`, candidate opid 1 (low bits) → it is treated as younger and is not claimed.
- `rst` asserted while `wb_num=3` → `wb`=0, `wb_num`=0, `claim`=0 next cycle.
